// File: rtl/sr_latch_network_pkg.sv
// Shared definitions for the SR-latch entropy network: LFSR geometry,
// sequencer phase type and the LFSR step function.
package sr_latch_network_pkg;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    EXCITE  = 1'b0,
    RELEASE = 1'b1
  } phase_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    logic [LFSR_W-1:0] nxt;
    nxt = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    return nxt;
  endfunction

endpackage

// File: rtl/sr_latch_network_cell.sv
// One emulated SR latch: S=R=1 marks the cell metastable, and releasing both
// inputs resolves it to the supplied noise bit.
module sr_latch_cell
  import sr_latch_network_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  input  logic noise,
  output logic q,
  output logic meta
);

  logic q_q, q_d;
  logic meta_q, meta_d;

  // Latch behaviour for each S/R combination
  always_comb begin
    q_d    = q_q;
    meta_d = meta_q;
    case ({s, r})
      2'b10: begin
        q_d    = 1'b1;
        meta_d = 1'b0;
      end
      2'b01: begin
        q_d    = 1'b0;
        meta_d = 1'b0;
      end
      2'b11: begin
        meta_d = 1'b1;
      end
      2'b00: begin
        if (meta_q) begin
          q_d    = noise;
          meta_d = 1'b0;
        end else begin
          q_d    = q_q;
          meta_d = meta_q;
        end
      end
      default: begin
        q_d    = q_q;
        meta_d = meta_q;
      end
    endcase
  end

  // Cell state register
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= 1'b0;
      meta_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      meta_q <= meta_d;
    end
  end

  assign q    = q_q;
  assign meta = meta_q;

endmodule

// File: rtl/sr_latch_network.sv
// Bank of emulated SR latches excited/released in alternation; the resolved
// bits are XOR-folded into one registered random bit.
module sr_latch_network
  import sr_latch_network_pkg::*;
#(
  parameter int          NUM_LATCHES = 8,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic enabled,
  output logic b
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
  phase_e                 phase_q, phase_d;
  logic                   pend_q, pend_d;
  logic                   b_q, b_d;
  logic [NUM_LATCHES-1:0] s_s, r_s, q_s, meta_s;

  // Cell drive; while disabled each cell is fed S=R=meta so it holds exactly
  always_comb begin
    s_s = meta_s;
    r_s = meta_s;
    if (enabled) begin
      if (phase_q == EXCITE) begin
        s_s = {NUM_LATCHES{1'b1}};
        r_s = {NUM_LATCHES{1'b1}};
      end else begin
        s_s = {NUM_LATCHES{1'b0}};
        r_s = {NUM_LATCHES{1'b0}};
      end
    end else begin
      s_s = meta_s;
      r_s = meta_s;
    end
  end

  // Sequencer, free-running noise source and output fold
  always_comb begin
    lfsr_d  = lfsr_step(lfsr_q);
    phase_d = EXCITE;
    pend_d  = pend_q;
    b_d     = b_q;
    if (enabled) begin
      case (phase_q)
        EXCITE:  phase_d = RELEASE;
        RELEASE: phase_d = EXCITE;
        default: phase_d = EXCITE;
      endcase
      if (pend_q) begin
        b_d    = ^q_s;
        pend_d = 1'b0;
      end else begin
        b_d = b_q;
      end
      if (phase_q == RELEASE) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_d;
      end
    end else begin
      phase_d = EXCITE;
    end
  end

  // Network state register
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q  <= SEED_EFF;
      phase_q <= EXCITE;
      pend_q  <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      b_q     <= b_d;
    end
  end

  for (genvar i = 0; i < NUM_LATCHES; i++) begin : gen_cells
    sr_latch_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .s     (s_s[i]),
      .r     (r_s[i]),
      .noise (lfsr_q[i]),
      .q     (q_s[i]),
      .meta  (meta_s[i])
    );
  end

  assign b = b_q;

endmodule

// File: tb/tb_sr_latch_network.sv
// Self-checking bench: an 8-cell and a 1-cell network share stimulus and are
// compared every cycle against a word-level reference model.
module tb_sr_latch_network;
  import sr_latch_network_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enabled = 1'b1;
  logic b8, b1;

  int tests = 0;
  int fails = 0;
  logic chk_on = 1'b0;

  sr_latch_network dut8 (.clk(clk), .reset(reset), .enabled(enabled), .b(b8));
  sr_latch_network #(.NUM_LATCHES(1)) dut1 (.clk(clk), .reset(reset), .enabled(enabled), .b(b1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference model: one metastable flag and one captured word stand for the whole bank
  logic [15:0] m_lfsr;
  logic        m_rel, m_excited, m_pend, m_b8, m_b1, m_newb;
  logic [15:0] m_qw;

  always @(posedge clk) begin
    m_newb <= 1'b0;
    if (reset) begin
      m_lfsr    <= 16'hACE1;
      m_rel     <= 1'b0;
      m_excited <= 1'b0;
      m_pend    <= 1'b0;
      m_qw      <= 16'h0000;
      m_b8      <= 1'b0;
      m_b1      <= 1'b0;
    end else begin
      m_lfsr <= ref_next(m_lfsr);
      if (enabled) begin
        m_rel <= ~m_rel;
        if (m_pend) begin
          m_b8   <= ^m_qw[7:0];
          m_b1   <= m_qw[0];
          m_pend <= 1'b0;
          m_newb <= 1'b1;
        end
        if (!m_rel) begin
          m_excited <= 1'b1;
        end else if (m_excited) begin
          m_qw      <= m_lfsr;
          m_excited <= 1'b0;
          m_pend    <= 1'b1;
        end
      end else begin
        m_rel <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("b8", 32'(b8), 32'(m_b8));
      check("b1", 32'(b1), 32'(m_b1));
      check("lfsr", 32'(dut8.lfsr_q), 32'(m_lfsr));
      check("phase", 32'(dut8.phase_q == RELEASE), 32'(m_rel));
      check("meta", 32'(dut8.meta_s), 32'(m_excited ? 8'hFF : 8'h00));
    end
  end

  initial begin
    int samples;
    int ones;
    int guard;
    logic held, exp_b;

    reset = 1'b1;
    enabled = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_b8", 32'(b8), 32'd0);
    check("rst_b1", 32'(b1), 32'd0);
    check("rst_lfsr", 32'(dut8.lfsr_q), 32'h0000ACE1);
    check("rst_phase", 32'(dut8.phase_q == EXCITE), 32'd1);

    reset = 1'b0;
    enabled = 1'b0;
    @(negedge clk);
    check("lfsr_first", 32'(dut8.lfsr_q), 32'h0000E270);
    repeat (19) begin
      @(negedge clk);
      check("idle_b8", 32'(b8), 32'd0);
    end

    enabled = 1'b1;
    samples = 0;
    ones = 0;
    repeat (2001) begin
      @(negedge clk);
      if (m_newb) begin
        samples++;
        ones += int'(b8);
      end
    end
    check("samples", 32'(samples), 32'd1000);
    tests++;
    if (ones < 450 || ones > 550) begin
      fails++;
      $display("FAIL ones_count: got %0d required 450..550", ones);
    end

    guard = 0;
    while (!m_rel && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    check("find_release", 32'(m_rel), 32'd1);
    enabled = 1'b0;
    held = m_b8;
    repeat (5) begin
      @(negedge clk);
      check("hold_b8", 32'(b8), 32'(held));
    end
    check("hold_meta", 32'(dut8.meta_s), 32'h000000FF);

    enabled = 1'b1;
    check("reenable_phase", 32'(dut8.phase_q == EXCITE), 32'd1);
    @(negedge clk);
    exp_b = ^m_lfsr[7:0];
    check("reen_b_e1", 32'(b8), 32'(held));
    @(negedge clk);
    check("reen_b_e2", 32'(b8), 32'(held));
    @(negedge clk);
    check("reen_b_e3", 32'(b8), 32'(exp_b));

    held = m_b8;
    for (int i = 0; i < 20; i++) begin
      enabled = i[0];
      @(negedge clk);
    end
    check("toggle_hold", 32'(b8), 32'(held));

    enabled = 1'b1;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_b8", 32'(b8), 32'd0);
    check("mid_rst_lfsr", 32'(dut8.lfsr_q), 32'h0000ACE1);
    check("mid_rst_meta", 32'(dut8.meta_s), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      enabled = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
